// File: rtl/blake2_pkg.sv
// Shared constants and state encoding for the blake2 message packer.
package blake2_pkg;

   localparam int unsigned W_B            = 64;  // blake2b word width
   localparam int unsigned W_S            = 32;  // blake2s word width
   localparam int unsigned BLOCK_WORDS    = 16;
   localparam int unsigned BYTES_PER_WORD = W_B / 8;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/blake2_byte_mask.sv
// Byte-enable mask for one message word: full word unless it is the last word,
// in which case only bytes below s_bytes_i survive. Counts above W/8 give a full word.
module blake2_byte_mask #(
   parameter int unsigned W  = 64,
   parameter int unsigned BW = $clog2(W / 8) + 1
) (
   input  logic [BW-1:0] s_bytes_i,
   input  logic          s_last_i,
   output logic [W-1:0]  mask_o
);

   // One byte lane per loop step
   always_comb begin
      mask_o = '0;
      for (int k = 0; k < int'(W / 8); k++) begin
         if (!s_last_i || (k < int'(s_bytes_i))) begin
            mask_o[8*k +: 8] = 8'hff;
         end
      end
   end

endmodule

// File: rtl/blake2_msg_pack.sv
// Packs a byte-granular word stream into zero-padded 16-word blake2 blocks with
// running byte offset t and final flag.
// Optional: define BLAKE2_MSG_PACK_ERR_EN to add a sticky err_o for illegal byte counts.
module blake2_msg_pack
   import blake2_pkg::*;
#(
   parameter int unsigned W  = 64,
   parameter int unsigned BW = $clog2(W / 8) + 1
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic                s_valid_i,
   output logic                s_ready_o,
   input  logic [W-1:0]        s_data_i,
   input  logic                s_last_i,
   input  logic [BW-1:0]       s_bytes_i,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [16*W-1:0]     m_data_o,
   output logic [2*W-1:0]      m_t_o,
`ifdef BLAKE2_MSG_PACK_ERR_EN
   output logic                m_final_o,
   output logic                err_o
`else
   output logic                m_final_o
`endif
);

   localparam int unsigned BPW = W / 8;
   localparam int unsigned IW  = $clog2(BLOCK_WORDS);

   state_e                  state_q;
   logic [IW-1:0]           idx_q;
   logic [2*W-1:0]          t_q;
   logic [16*W-1:0]         buf_q;
   logic                    final_q;

   logic [W-1:0]            mask;
   logic [BW-1:0]           cnt;
   logic                    accept;

   blake2_byte_mask #(
      .W  (W),
      .BW (BW)
   ) u_byte_mask (
      .s_bytes_i (s_bytes_i),
      .s_last_i  (s_last_i),
      .mask_o    (mask)
   );

   assign accept = s_valid_i && (state_q == FILL);

   // Bytes contributed to t by the current word, clamped to a full word
   always_comb begin
      cnt = BW'(BPW);
      if (s_last_i && (s_bytes_i <= BW'(BPW))) begin
         cnt = s_bytes_i;
      end
   end

   // Block assembly FSM: fill words, then hold the block until the core takes it
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= FILL;
         idx_q   <= '0;
         t_q     <= '0;
         buf_q   <= '0;
         final_q <= 1'b0;
      end else begin
         unique case (state_q)
            FILL: begin
               if (accept) begin
                  buf_q[int'(idx_q)*W +: W] <= s_data_i & mask;
                  t_q <= t_q + (2*W)'(cnt);
                  if ((idx_q == IW'(BLOCK_WORDS - 1)) || s_last_i) begin
                     state_q <= HOLD;
                     final_q <= s_last_i;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (m_ready_i) begin
                  // Clearing here is what zero-pads the next block
                  buf_q   <= '0;
                  idx_q   <= '0;
                  state_q <= FILL;
                  if (final_q) begin
                     t_q     <= '0;
                     final_q <= 1'b0;
                  end
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign s_ready_o = (state_q == FILL);
   assign m_valid_o = (state_q == HOLD);
   assign m_data_o  = buf_q;
   assign m_t_o     = t_q;
   assign m_final_o = final_q;

`ifdef BLAKE2_MSG_PACK_ERR_EN
   logic err_q;

   // Sticky flag for an oversize count, or a zero count that is not a whole empty message
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         err_q <= 1'b0;
      end else if (accept && s_last_i &&
                   ((s_bytes_i > BW'(BPW)) ||
                    ((s_bytes_i == '0) && ((idx_q != '0) || (t_q != '0))))) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`endif

endmodule
